seg_scan: RTL and testbench

- Display back-end for the filling controller; consumes the six BCD digit codes the page selector emits (out6..out1).
- Time-multiplexes them onto a common-anode 6-digit 7-segment module.
- Provides frame-coherent digit capture, blink of digits being edited in SET mode, leading-zero suppression and a per-digit decimal point.

---
 rtl/seg_scan.sv | 158 +++++++++++++++
 tb/tb_seg_scan.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Six-digit common-anode 7-segment scanner with frame-coherent snapshot,
// leading-zero suppression, per-digit blink and decimal point.
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] out6,
    input  logic [3:0] out5,
    input  logic [3:0] out4,
    input  logic [3:0] out3,
    input  logic [3:0] out2,
    input  logic [3:0] out1,
    input  logic [5:0] BLINK,
    input  logic [5:0] DP_IN,
    input  logic       LZS,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]      prescaler;
    logic [2:0]         idx;
    logic               started;
    logic [5:0][3:0]    snap_code;
    logic [5:0]         snap_blink;
    logic [5:0]         snap_dp;
    logic               snap_lzs;
    logic [BW-1:0]      blink_cnt;
    logic               phase;

    logic               tick;
    logic               frame_end;
    logic               load;
    logic [5:0]         sup;
    logic               run;
    logic [3:0]         cur_code;
    logic               cur_blink;
    logic               cur_dp;
    logic               cur_sup;
    logic               blank;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick      = (prescaler == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == 3'd5);
    // The first enabled cycle after reset must capture inputs so the display
    // does not stay blank for a whole frame.
    assign load      = !started || frame_end;

    // Leading-zero run from the leftmost position; position 0 always shows.
    always_comb begin
        sup = '0;
        run = snap_lzs;
        for (int p = 5; p >= 1; p--) begin
            run    = run && (snap_code[p] == 4'd0);
            sup[p] = run;
        end
    end

    always_comb begin
        cur_code  = 4'hF;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        cur_sup   = 1'b0;
        for (int p = 0; p < 6; p++) begin
            if (idx == 3'(p)) begin
                cur_code  = snap_code[p];
                cur_blink = snap_blink[p];
                cur_dp    = snap_dp[p];
                cur_sup   = sup[p];
            end
        end
        blank = cur_sup || (cur_blink && !phase);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prescaler <= '0;
            idx       <= 3'd0;
            started   <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            started <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            snap_code  <= {6{4'hF}};
            snap_blink <= '0;
            snap_dp    <= '0;
            snap_lzs   <= 1'b0;
        end else if (load) begin
            snap_code  <= {out6, out5, out4, out3, out2, out1};
            snap_blink <= BLINK;
            snap_dp    <= DP_IN;
            snap_lzs   <= LZS;
        end
    end

    // Holding the blink timer while nothing blinks makes every new blink
    // request start in the visible half.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (BLINK == 6'd0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Blanking only darkens segments and DP; the anode still scans.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            AN  <= 6'h3F;
            SEG <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(6'b000001 << idx);
            SEG <= blank ? 7'h7F : decode(cur_code);
            DP  <= blank || !cur_dp;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed test-plan checks plus randomized traffic,
// all compared against a frame/slot arithmetic model of the display.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 6 * SD;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [5:0][3:0] dig;
  logic [5:0]      blink;
  logic [5:0]      dp_in;
  logic            lzs;
  logic [5:0]      an;
  logic [6:0]      seg;
  logic            dp;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .CLK(clk), .RST_N(rst_n),
    .out6(dig[5]), .out5(dig[4]), .out4(dig[3]),
    .out3(dig[2]), .out2(dig[1]), .out1(dig[0]),
    .BLINK(blink), .DP_IN(dp_in), .LZS(lzs),
    .AN(an), .SEG(seg), .DP(dp)
  );

  // reference model state
  int              m_t;
  bit              m_started;
  logic [5:0][3:0] m_code;
  logic [5:0]      m_blink;
  logic [5:0]      m_dp;
  logic            m_lzs;
  int              m_cnt;
  bit              m_phase;
  logic [5:0]      e_an;
  logic [6:0]      e_seg;
  logic            e_dp;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [5:0] an_seq [6] = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] cap_seg [6];
  logic       cap_dp  [6];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // One rising edge of the model: outputs come from the state before the edge.
  task automatic model_step();
    int  idx;
    bit  frame_end;
    bit  blank;
    bit  zero_run;
    logic [5:0] sup;
    if (!rst_n) begin
      m_t = 0; m_started = 0; m_code = {6{4'hF}}; m_blink = '0; m_dp = '0;
      m_lzs = 0; m_cnt = 0; m_phase = 1;
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
      return;
    end
    idx       = (m_t / SD) % 6;
    frame_end = (m_t % FR) == (FR - 1);
    sup = '0;
    zero_run = m_lzs;
    for (int p = 5; p >= 1; p--) begin
      if (m_code[p] != 4'd0) zero_run = 0;
      sup[p] = zero_run;
    end
    blank = sup[idx] || (m_blink[idx] && !m_phase);
    e_an      = 6'h3F;
    e_an[idx] = 1'b0;
    e_seg     = blank ? 7'h7F : seg_tab[m_code[idx]];
    e_dp      = blank ? 1'b1 : !m_dp[idx];
    if (!m_started || frame_end) begin
      m_code = dig; m_blink = blink; m_dp = dp_in; m_lzs = lzs;
    end
    m_started = 1;
    if (blink == 6'd0) begin
      m_cnt = 0; m_phase = 1;
    end else if (frame_end) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0; m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_t++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("an", {2'b0, an}, {2'b0, e_an});
    check("seg", {1'b0, seg}, {1'b0, e_seg});
    check("dp", {7'b0, dp}, {7'b0, e_dp});
    for (int p = 0; p < 6; p++) begin
      if (an == ~(6'b000001 << p)) begin
        cap_seg[p] = seg;
        cap_dp[p]  = dp;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_cap();
    for (int p = 0; p < 6; p++) begin
      cap_seg[p] = 'x;
      cap_dp[p]  = 1'bx;
    end
  endtask

  // Advance until the next edge processed is the given offset within a frame.
  task automatic run_to(input int off);
    for (int k = 0; k < FR; k++) begin
      if ((m_t % FR) == off) break;
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    dig   = {4'h9, 4'h8, 4'hA, 4'h2, 4'h1, 4'h0};
    blink = '0;
    dp_in = '0;
    lzs   = 1'b0;
    clear_cap();

    // reset and scan order
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_an", {2'b0, an}, 8'h3F);
      check("rst_seg", {1'b0, seg}, 8'h7F);
      check("rst_dp", {7'b0, dp}, 8'h01);
    end
    rst_n = 1'b1;
    cycle();
    check("rel_an", {2'b0, an}, 8'h3E);
    cycle();
    check("rel_pos0", {1'b0, seg}, 8'h40);
    run(SD - 1);
    check("an_step0", {2'b0, an}, {2'b0, an_seq[0]});
    for (int s = 1; s < 6; s++) begin
      run(SD);
      check("an_step", {2'b0, an}, {2'b0, an_seq[s]});
    end

    // decode sweep
    run(FR);
    clear_cap();
    run(FR);
    check("dec0", {1'b0, cap_seg[0]}, 8'h40);
    check("dec1", {1'b0, cap_seg[1]}, 8'h79);
    check("dec2", {1'b0, cap_seg[2]}, 8'h24);
    check("dec3", {1'b0, cap_seg[3]}, 8'h3F);
    check("dec4", {1'b0, cap_seg[4]}, 8'h00);
    check("dec5", {1'b0, cap_seg[5]}, 8'h10);

    // leading-zero suppression
    dig = {4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h7};
    lzs = 1'b1;
    run(2 * FR);
    clear_cap();
    run(FR);
    check("lzs0", {1'b0, cap_seg[0]}, 8'h78);
    check("lzs1", {1'b0, cap_seg[1]}, 8'h40);
    check("lzs2", {1'b0, cap_seg[2]}, 8'h40);
    check("lzs3", {1'b0, cap_seg[3]}, 8'h30);
    check("lzs4", {1'b0, cap_seg[4]}, 8'h7F);
    check("lzs5", {1'b0, cap_seg[5]}, 8'h7F);
    dig = '0;
    run(2 * FR);
    clear_cap();
    run(FR);
    check("lzs_all0", {1'b0, cap_seg[0]}, 8'h40);
    for (int p = 1; p < 6; p++) check("lzs_allblank", {1'b0, cap_seg[p]}, 8'h7F);

    // frame coherence
    lzs = 1'b0;
    dig = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    run(2 * FR);
    clear_cap();
    run(FR);
    check("coh_old0", {1'b0, cap_seg[0]}, 8'h79);
    run_to(2 * SD);
    dig[0] = 4'h5;
    dig[5] = 4'h8;
    clear_cap();
    run(4 * SD);
    check("coh_hold5", {1'b0, cap_seg[5]}, 8'h40);
    clear_cap();
    run(FR);
    check("coh_new0", {1'b0, cap_seg[0]}, 8'h12);
    check("coh_new5", {1'b0, cap_seg[5]}, 8'h00);

    // blink, two frames visible / two blank
    dig   = {4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3};
    dp_in = 6'b000011;
    run(2 * FR);
    run_to(0);
    blink = 6'b000011;
    for (int k = 0; k < 6; k++) begin
      bit b;
      b = (k % 4) >= 2;
      clear_cap();
      run(FR);
      check("blk_seg0", {1'b0, cap_seg[0]}, b ? 8'h7F : 8'h30);
      check("blk_seg1", {1'b0, cap_seg[1]}, b ? 8'h7F : 8'h19);
      check("blk_dp0", {7'b0, cap_dp[0]}, b ? 8'h01 : 8'h00);
      check("blk_seg2", {1'b0, cap_seg[2]}, 8'h40);
    end
    run(FR / 2);
    blink = '0;
    run(FR - FR / 2);
    clear_cap();
    run(FR);
    check("blk_clear0", {1'b0, cap_seg[0]}, 8'h30);
    check("blk_clear_dp", {7'b0, cap_dp[1]}, 8'h00);

    // decimal point and mid-frame reset
    dig   = {4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    dp_in = 6'b000100;
    run(2 * FR);
    clear_cap();
    run(FR);
    for (int p = 0; p < 6; p++) check("dp_pos", {7'b0, cap_dp[p]}, (p == 2) ? 8'h00 : 8'h01);
    run_to(3 * SD + 1);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_an", {2'b0, an}, 8'h3F);
    check("mid_rst_seg", {1'b0, seg}, 8'h7F);
    check("mid_rst_dp", {7'b0, dp}, 8'h01);
    rst_n = 1'b1;
    run(2 * FR);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 6; p++)
        dig[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 2) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(1, 9));
      blink = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      dp_in = 6'($urandom_range(0, 63));
      lzs   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      run($urandom_range(1, 3 * FR));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
